// File: rtl/door_ctrl.sv
// Door lifecycle sequencer for the level exit, plus the registered door-sprite
// frame RAM addressing derived from the VGA draw position and camera offset.
module door_ctrl #(
  parameter int unsigned DOOR_LEFT   = 2416,
  parameter int unsigned DOOR_TOP    = 96,
  parameter int unsigned DOOR_W      = 60,
  parameter int unsigned DOOR_H      = 80,
  parameter int unsigned OPEN_STEP   = 4,
  parameter int unsigned EXIT_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        key_got,
  input  logic [11:0] zerox,
  input  logic [9:0]  drawx,
  input  logic [9:0]  drawy,
  input  logic [11:0] p1_x,
  input  logic [11:0] p1_y,
  input  logic [11:0] p2_x,
  input  logic [11:0] p2_y,
  input  logic        p1_up,
  input  logic        p2_up,
  output logic [12:0] read_address,
  output logic        door_hit,
  output logic        open_mask,
  output logic [6:0]  open_cols,
  output logic [2:0]  door_state,
  output logic [1:0]  players_in,
  output logic        level_done
);

  localparam logic [11:0] X_LO = 12'(DOOR_LEFT);
  localparam logic [11:0] X_HI = 12'(DOOR_LEFT + DOOR_W);
  localparam logic [11:0] Y_LO = 12'(DOOR_TOP);
  localparam logic [11:0] Y_HI = 12'(DOOR_TOP + DOOR_H);
  localparam int unsigned CW   = $clog2(EXIT_FRAMES + 1);

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    UNLOCKED = 3'd1,
    OPENING  = 3'd2,
    OPEN     = 3'd3,
    EXIT     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t        r_state;
  logic [6:0]    r_open_cols;
  logic [1:0]    r_players_in;
  logic          r_level_done;
  logic [CW-1:0] r_exit_cnt;
  logic [12:0]   r_read_address;
  logic          r_door_hit;
  logic          r_open_mask;

  function automatic logic in_rect(input logic [11:0] x, input logic [11:0] y);
    return (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  endfunction

  logic [11:0] w_nowx;
  logic [11:0] w_nowy;
  logic [11:0] w_col;
  logic [11:0] w_row;
  logic        w_inside;
  logic        w_open_px;
  logic [12:0] w_addr;
  logic        w_p1_at;
  logic        w_p2_at;
  logic [7:0]  w_cols_sum;
  logic        w_cols_full;

  always_comb begin
    w_nowx      = {2'b0, drawx} + zerox;
    w_nowy      = {2'b0, drawy};
    w_inside    = in_rect(w_nowx, w_nowy);
    w_col       = w_nowx - X_LO;
    w_row       = w_nowy - Y_LO;
    w_addr      = w_inside ? 13'(w_row * DOOR_W + w_col) : '0;
    w_open_px   = w_inside && (w_col < {5'b0, r_open_cols});
    w_p1_at     = in_rect(p1_x, p1_y);
    w_p2_at     = in_rect(p2_x, p2_y);
    w_cols_sum  = {1'b0, r_open_cols} + 8'(OPEN_STEP);
    w_cols_full = (w_cols_sum >= 8'(DOOR_W));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= LOCKED;
      r_open_cols    <= '0;
      r_players_in   <= '0;
      r_level_done   <= 1'b0;
      r_exit_cnt     <= '0;
      r_read_address <= '0;
      r_door_hit     <= 1'b0;
      r_open_mask    <= 1'b0;
    end else begin
      r_read_address <= w_addr;
      r_door_hit     <= w_inside;
      r_open_mask    <= w_open_px;
      case (r_state)
        LOCKED:   if (key_got) r_state <= UNLOCKED;
        UNLOCKED: if ((w_p1_at && p1_up) || (w_p2_at && p2_up)) r_state <= OPENING;
        OPENING: begin
          if (frame_tick) begin
            if (w_cols_full) begin
              r_open_cols <= 7'(DOOR_W);
              r_state     <= OPEN;
            end else begin
              r_open_cols <= w_cols_sum[6:0];
            end
          end
        end
        OPEN: begin
          // Exit is taken from the registered bits, so a simultaneous double
          // entry shows players_in=11 for one cycle before EXIT.
          if (w_p1_at && p1_up) r_players_in[0] <= 1'b1;
          if (w_p2_at && p2_up) r_players_in[1] <= 1'b1;
          if (r_players_in == 2'b11) begin
            r_state    <= EXIT;
            r_exit_cnt <= '0;
          end
        end
        EXIT: begin
          if (frame_tick) begin
            if (r_exit_cnt == CW'(EXIT_FRAMES - 1)) begin
              r_state      <= DONE;
              r_level_done <= 1'b1;
            end else begin
              r_exit_cnt <= r_exit_cnt + 1'b1;
            end
          end
        end
        DONE:     r_level_done <= 1'b1;
        default:  r_state <= LOCKED;
      endcase
    end
  end

  assign read_address = r_read_address;
  assign door_hit     = r_door_hit;
  assign open_mask    = r_open_mask;
  assign open_cols    = r_open_cols;
  assign door_state   = r_state;
  assign players_in   = r_players_in;
  assign level_done   = r_level_done;

endmodule
